// File: rtl/weightmemory_layer_sequencer_if.sv
// Handshake bundle between the layer sequencer, the weight memory controller
// and the compute pipeline. Signal suffixes are relative to the sequencer.
interface weightmemory_layer_sequencer_if #(
    parameter int K   = 3,
    parameter int N_I = 512,
    parameter int N_O = 512
);
    localparam int KW  = $clog2(K) + 1;
    localparam int NIW = $clog2(N_I) + 1;
    localparam int NOW = $clog2(N_O) + 1;

    logic           wmc_ready_i;
    logic           layer_done_i;
    logic           latch_new_layer_o;
    logic [KW-1:0]  layer_k_o;
    logic [NIW-1:0] layer_ni_o;
    logic [NOW-1:0] layer_no_o;
    logic           toggle_banks_o;
    logic           soft_reset_o;
    logic           compute_start_o;

    modport master (
        input  wmc_ready_i, layer_done_i,
        output latch_new_layer_o, layer_k_o, layer_ni_o, layer_no_o,
               toggle_banks_o, soft_reset_o, compute_start_o
    );

    modport slave (
        output wmc_ready_i, layer_done_i,
        input  latch_new_layer_o, layer_k_o, layer_ni_o, layer_no_o,
               toggle_banks_o, soft_reset_o, compute_start_o
    );
endinterface

// File: rtl/weightmemory_layer_sequencer.sv
// Walks the weight memory controller through a stack of layer descriptors,
// repeated over a number of image tiles.
//
//  state        | meaning
//  -------------+-------------------------------------------------------
//  S_IDLE       | waiting for start, descriptor writes accepted
//  S_LATCH      | controller latches the current descriptor
//  S_TOGGLE     | controller swaps weight banks
//  S_WAIT_READY | waiting for controller ready
//  S_START      | compute pipeline start pulse
//  S_RUN        | layer computing, waiting for layer_done
//  S_TILE_RST   | soft reset so weight addressing restarts for next tile
//  S_DONE       | run-complete pulse
module weightmemory_layer_sequencer #(
    parameter int N_I        = 512,
    parameter int N_O        = 512,
    parameter int K          = 3,
    parameter int NUM_LAYERS = 8,
    parameter int TILE_W     = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            cfg_we_i,
    input  logic [$clog2(NUM_LAYERS)-1:0]   cfg_addr_i,
    input  logic [$clog2(K):0]              cfg_k_i,
    input  logic [$clog2(N_I):0]            cfg_ni_i,
    input  logic [$clog2(N_O):0]            cfg_no_i,
    input  logic                            start_i,
    input  logic [$clog2(NUM_LAYERS):0]     num_layers_i,
    input  logic [TILE_W-1:0]               num_tiles_i,
    input  logic                            abort_i,
    weightmemory_layer_sequencer_if.master  wmc,
    output logic [$clog2(NUM_LAYERS)-1:0]   layer_idx_o,
    output logic [TILE_W-1:0]               tile_idx_o,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            cfg_err_o
);
    localparam int LW  = $clog2(NUM_LAYERS);
    localparam int KW  = $clog2(K) + 1;
    localparam int NIW = $clog2(N_I) + 1;
    localparam int NOW = $clog2(N_O) + 1;
    localparam logic [LW:0] NL_MAX = (LW+1)'(NUM_LAYERS);

    typedef enum logic [2:0] {
        S_IDLE, S_LATCH, S_TOGGLE, S_WAIT_READY, S_START, S_RUN, S_TILE_RST, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [LW-1:0]     layer_idx_q;
    logic [TILE_W-1:0] tile_idx_q;
    logic [LW:0]       num_layers_q;
    logic [TILE_W-1:0] num_tiles_q;
    logic              cfg_err_q;
    logic [KW-1:0]     slot_k  [NUM_LAYERS];
    logic [NIW-1:0]    slot_ni [NUM_LAYERS];
    logic [NOW-1:0]    slot_no [NUM_LAYERS];

    logic start_acc, abort_act, last_layer, last_tile, cfg_legal, layer_adv;
    logic latch_d, toggle_d, soft_d, cstart_d, done_d;
    logic [LW:0] num_layers_clamped;

    assign start_acc  = (state_q == S_IDLE) && start_i;
    assign abort_act  = (state_q != S_IDLE) && abort_i;
    assign last_layer = ({1'b0, layer_idx_q} == (num_layers_q - (LW+1)'(1)));
    assign last_tile  = (tile_idx_q == (num_tiles_q - TILE_W'(1)));
    assign layer_adv  = (state_q == S_RUN) && wmc.layer_done_i && !abort_act;

    // More layers than slots cannot be addressed; cap the count at the slot count.
    assign num_layers_clamped = (num_layers_i > NL_MAX) ? NL_MAX : num_layers_i;

    assign cfg_legal = cfg_k_i[0]
                    && (cfg_k_i <= KW'(K))
                    && (cfg_ni_i != '0) && (cfg_ni_i <= NIW'(N_I))
                    && (cfg_no_i != '0) && (cfg_no_i <= NOW'(N_O))
                    && ({1'b0, cfg_addr_i} < NL_MAX);

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state and strobe decode; abort overrides every transition.
    always_comb begin
        state_d  = state_q;
        latch_d  = 1'b0;
        toggle_d = 1'b0;
        soft_d   = 1'b0;
        cstart_d = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (num_layers_i == '0 || num_tiles_i == '0) state_d = S_DONE;
                    else                                         state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                latch_d = 1'b1;
                state_d = S_TOGGLE;
            end
            S_TOGGLE: begin
                toggle_d = 1'b1;
                state_d  = S_WAIT_READY;
            end
            S_WAIT_READY: begin
                if (wmc.wmc_ready_i) state_d = S_START;
            end
            S_START: begin
                cstart_d = 1'b1;
                state_d  = S_RUN;
            end
            S_RUN: begin
                if (wmc.layer_done_i) begin
                    if (!last_layer)     state_d = S_LATCH;
                    else if (!last_tile) state_d = S_TILE_RST;
                    else                 state_d = S_DONE;
                end
            end
            S_TILE_RST: begin
                soft_d  = 1'b1;
                state_d = S_LATCH;
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort_act) begin
            state_d = S_IDLE;
            soft_d  = 1'b1;
        end
    end

    // Layer/tile counters and sampled run lengths.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            layer_idx_q  <= '0;
            tile_idx_q   <= '0;
            num_layers_q <= '0;
            num_tiles_q  <= '0;
        end else if (start_acc) begin
            layer_idx_q  <= '0;
            tile_idx_q   <= '0;
            num_layers_q <= num_layers_clamped;
            num_tiles_q  <= num_tiles_i;
        end else if (layer_adv) begin
            if (!last_layer) begin
                layer_idx_q <= layer_idx_q + LW'(1);
            end else if (!last_tile) begin
                layer_idx_q <= '0;
                tile_idx_q  <= tile_idx_q + TILE_W'(1);
            end
        end
    end

    // Descriptor slots and sticky error flag; only writable while idle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cfg_err_q <= 1'b0;
            for (int i = 0; i < NUM_LAYERS; i++) begin
                slot_k[i]  <= KW'(K);
                slot_ni[i] <= NIW'(N_I);
                slot_no[i] <= NOW'(N_O);
            end
        end else begin
            if (start_acc) cfg_err_q <= 1'b0;
            if (state_q == S_IDLE && cfg_we_i) begin
                if (cfg_legal) begin
                    slot_k[cfg_addr_i]  <= cfg_k_i;
                    slot_ni[cfg_addr_i] <= cfg_ni_i;
                    slot_no[cfg_addr_i] <= cfg_no_i;
                end else begin
                    cfg_err_q <= 1'b1;
                end
            end
        end
    end

    assign wmc.latch_new_layer_o = latch_d;
    assign wmc.toggle_banks_o    = toggle_d;
    assign wmc.soft_reset_o      = soft_d;
    assign wmc.compute_start_o   = cstart_d;
    assign wmc.layer_k_o         = slot_k[layer_idx_q];
    assign wmc.layer_ni_o        = slot_ni[layer_idx_q];
    assign wmc.layer_no_o        = slot_no[layer_idx_q];
    assign done_o                = done_d;
    assign busy_o                = (state_q != S_IDLE);
    assign layer_idx_o           = layer_idx_q;
    assign tile_idx_o            = tile_idx_q;
    assign cfg_err_o             = cfg_err_q;
endmodule
